// File: rtl/protocolo_dac_pkg.sv
// Shared ADC/DAC serial protocol definitions: FSM encodings and frame layout.
package protocolo_dac_pkg;

    typedef enum logic [1:0] {
        INICIO     = 2'b00,
        TRANSMITIR = 2'b01,
        LISTO      = 2'b10
    } estado_t;

    localparam int ANCHO_TRAMA = 16;
    localparam int MODO_MSB    = 13;
    localparam int MODO_LSB    = 12;
    localparam int ANCHO_CONT  = 4;

endpackage

// File: rtl/protocolo_dac.sv
// Serial DAC frame transmitter: 16-bit frame {00, PD1:PD0, sample}, MSB first,
// SYNC (CS) low for the frame and held high for a programmable holdoff.
module protocolo_dac
    import protocolo_dac_pkg::*;
#(
    parameter int ANCHO_DATO  = 12,
    parameter int CS_ALTO_MIN = 2
) (
    input  logic                  Clock_Muestreo,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ANCHO_DATO-1:0] Dato,
    input  logic [1:0]            modo,
    output logic                  CS,
    output logic                  data_DAC,
    output logic                  busy,
    output logic                  done
);

    estado_t                 r_estado, w_estado_sig;
    logic [ANCHO_TRAMA-1:0]  r_trama, w_trama_sig, w_trama_nueva;
    logic [ANCHO_CONT-1:0]   r_cont, w_cont_sig;
    logic                    r_cs, r_data, r_busy, r_done;

    always_comb begin
        w_trama_nueva                    = '0;
        w_trama_nueva[MODO_MSB:MODO_LSB] = modo;
        w_trama_nueva[ANCHO_DATO-1:0]    = Dato;
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_estado_sig = r_estado;
        w_trama_sig  = r_trama;
        w_cont_sig   = r_cont;
        case (r_estado)
            INICIO: begin
                if (start) begin
                    w_estado_sig = TRANSMITIR;
                    w_trama_sig  = w_trama_nueva;
                    w_cont_sig   = '0;
                end
            end
            TRANSMITIR: begin
                w_trama_sig = {r_trama[ANCHO_TRAMA-2:0], 1'b0};
                if (r_cont == ANCHO_CONT'(ANCHO_TRAMA - 1)) begin
                    w_estado_sig = LISTO;
                    w_cont_sig   = '0;
                end else begin
                    w_cont_sig = r_cont + 1'b1;
                end
            end
            LISTO: begin
                if (r_cont == ANCHO_CONT'(CS_ALTO_MIN - 1)) begin
                    w_estado_sig = INICIO;
                    w_cont_sig   = '0;
                end else begin
                    w_cont_sig = r_cont + 1'b1;
                end
            end
            default: begin
                w_estado_sig = INICIO;
                w_trama_sig  = '0;
                w_cont_sig   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state itself.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge Clock_Muestreo) begin
        if (reset) begin
            r_estado <= INICIO;
            r_trama  <= '0;
            r_cont   <= '0;
            r_cs     <= 1'b1;
            r_data   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_estado <= w_estado_sig;
            r_trama  <= w_trama_sig;
            r_cont   <= w_cont_sig;
            r_cs     <= (w_estado_sig != TRANSMITIR);
            r_data   <= (w_estado_sig == TRANSMITIR) && w_trama_sig[ANCHO_TRAMA-1];
            r_busy   <= (w_estado_sig != INICIO);
            r_done   <= (r_estado == TRANSMITIR) && (w_estado_sig == LISTO);
        end
    end

    assign CS       = r_cs;
    assign data_DAC = r_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

// File: tb/tb_protocolo_dac.sv
// Directed bench for protocolo_dac: checks {CS,busy,done,data_DAC} every cycle of each scenario.
module tb_protocolo_dac;

    localparam int ANCHO_DATO  = 12;
    localparam int CS_ALTO_MIN = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  start;
    logic [ANCHO_DATO-1:0] dato;
    logic [1:0]            modo;
    logic                  cs, data_dac, busy, done;
    logic [3:0]            w_obs;

    int checks = 0;
    int errors = 0;

    protocolo_dac #(
        .ANCHO_DATO (ANCHO_DATO),
        .CS_ALTO_MIN(CS_ALTO_MIN)
    ) dut (
        .Clock_Muestreo(clk),
        .reset         (reset),
        .start         (start),
        .Dato          (dato),
        .modo          (modo),
        .CS            (cs),
        .data_DAC      (data_dac),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    assign w_obs = {cs, busy, done, data_dac};

    // Expected {CS,busy,done,data} in cycle T+k of a frame accepted at cycle T.
    function automatic logic [3:0] esperado(input int k, input logic [15:0] f);
        if (k >= 1 && k <= 16)                return {1'b0, 1'b1, 1'b0, f[16-k]};
        if (k == 17)                          return 4'b1110;
        if (k >= 18 && k <= 16 + CS_ALTO_MIN) return 4'b1100;
        return 4'b1000;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b1;
        dato  = 12'hFFF;
        modo  = 2'b00;
        step();
        step();
        checks++;
        if (w_obs !== 4'b1000) begin
            errors++;
            $display("FAIL reset_state got %b expected %b", w_obs, 4'b1000);
        end
        reset = 1'b0;
        start = 1'b0;
        step();
        checks++;
        if (w_obs !== 4'b1000) begin
            errors++;
            $display("FAIL start_with_reset got %b expected %b", w_obs, 4'b1000);
        end
    endtask

    task automatic test_frame(input string nombre, input logic [11:0] d,
                              input logic [1:0] m, input logic [15:0] f);
        logic [3:0] exp_v;
        dato  = d;
        modo  = m;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) start = 1'b0;
            exp_v = esperado(k, f);
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL %s k=%0d got %b expected %b", nombre, k, w_obs, exp_v);
            end
        end
    endtask

    task automatic test_dato_change();
        logic [3:0] exp_v;
        dato  = 12'hFFF;
        modo  = 2'b00;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                dato = 12'h000;
                modo = 2'b11;
            end
            exp_v = esperado(k, 16'h0FFF);
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL dato_change k=%0d got %b expected %b", k, w_obs, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_v;
        dato  = 12'hA5C;
        modo  = 2'b00;
        start = 1'b1;
        for (int k = 1; k <= 38; k++) begin
            step();
            if (k == 1) begin
                dato = 12'h123;
                modo = 2'b01;
            end
            if (k == 20) start = 1'b0;
            exp_v = (k <= 19) ? esperado(k, 16'h0A5C) : esperado(k - 19, 16'h1123);
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back k=%0d got %b expected %b", k, w_obs, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_v;
        dato  = 12'hFFF;
        modo  = 2'b00;
        start = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            step();
            if (k == 1) start = 1'b0;
            if (k == 9) reset = 1'b0;
            exp_v = (k <= 8) ? esperado(k, 16'h0FFF) : 4'b1000;
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL reset_mid k=%0d got %b expected %b", k, w_obs, exp_v);
            end
            if (k == 8) reset = 1'b1;
        end
        test_frame("post_reset_frame", 12'h5A3, 2'b10, 16'h25A3);
    endtask

    task automatic test_start_ignored();
        logic [3:0] exp_v;
        dato  = 12'h0F0;
        modo  = 2'b01;
        start = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step();
            case (k)
                1, 11, 18: start = 1'b0;
                10, 17:    start = 1'b1;
                default:   ;
            endcase
            exp_v = esperado(k, 16'h10F0);
            checks++;
            if (w_obs !== exp_v) begin
                errors++;
                $display("FAIL start_ignored k=%0d got %b expected %b", k, w_obs, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        dato  = '0;
        modo  = '0;
        test_reset();
        test_frame("frame_a5c", 12'hA5C, 2'b00, 16'h0A5C);
        test_frame("frame_modo11", 12'hFFF, 2'b11, 16'h3FFF);
        test_dato_change();
        test_back_to_back();
        test_reset_mid();
        test_start_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
